// File: rtl/debug_probe_sched.sv
// rtl/debug_probe_sched.sv - frame-synchronous probe scheduler for the hex debug overlay
//
// Captures up to NUM_CH 64-bit probes on their strobes. One channel is selected
// per display period, either by manual advance or by auto-cycling. The selected
// snapshot is handed to the overlay only at frame origin, so digits never tear
// mid-frame.
//
// Ports:
//   clk          pixel clock, all logic on the rising edge
//   i_reset      synchronous reset, active-high
//   i_h, i_v     beam counters, the same ones that feed the overlay
//   i_probe      NUM_CH probe values, channel k at [64k+63:64k]
//   i_probe_stb  per-channel capture strobe
//   i_next       manual advance level, acts on its rising edge
//   i_auto       1 = auto-cycle, FRAMES_PER_CH transfers per channel
//   i_freeze     1 = hold o_debug / o_chan / o_stale
//   o_debug      value shown by the overlay
//   o_chan       channel index currently displayed
//   o_stale      displayed snapshot had no strobe since that channel was last shown
//   o_frame_stb  one-clock pulse following each frame-origin transfer
module debug_probe_sched #(
  parameter int NUM_CH        = 4,
  parameter int FRAMES_PER_CH = 60
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic [11:0]           i_h,
  input  logic [11:0]           i_v,
  input  logic [64*NUM_CH-1:0]  i_probe,
  input  logic [NUM_CH-1:0]     i_probe_stb,
  input  logic                  i_next,
  input  logic                  i_auto,
  input  logic                  i_freeze,
  output logic [63:0]           o_debug,
  output logic [2:0]            o_chan,
  output logic                  o_stale,
  output logic                  o_frame_stb
);

  localparam logic [2:0]  LAST_CH   = 3'(NUM_CH - 1);
  localparam logic [11:0] LAST_FCNT = 12'(FRAMES_PER_CH - 1);

  logic [63:0]       cap [NUM_CH];
  logic [NUM_CH-1:0] fresh;
  logic [2:0]        sel;
  logic [11:0]       fcnt;
  logic              org_d;
  logic              next_d;

  logic              at_org;
  logic              xfer;
  logic              do_xfer;
  logic              next_rise;
  logic              auto_wrap;
  logic              advance;
  logic [2:0]        sel_next;
  logic [63:0]       cap_sel;
  logic              fresh_sel;

  always_comb begin
    at_org    = (i_h == 12'd0) && (i_v == 12'd0);
    // Only the first clock of a (possibly multi-clock) origin transfers.
    xfer      = at_org && !org_d;
    do_xfer   = xfer && !i_freeze;
    next_rise = i_next && !next_d;
    auto_wrap = i_auto && xfer && (fcnt == LAST_FCNT);
    // A button edge coinciding with an auto wrap still yields a single step.
    advance   = next_rise || auto_wrap;
    sel_next  = (sel == LAST_CH) ? 3'd0 : sel + 3'd1;
  end

  // Explicit compare mux keeps the 3-bit sel decoupled from the bank size.
  always_comb begin
    cap_sel   = '0;
    fresh_sel = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == 3'(k)) begin
        cap_sel   = cap[k];
        fresh_sel = fresh[k];
      end
    end
  end

  // Capture bank. A strobe on the channel being transferred wins over the
  // clear, so a value arriving exactly at origin is still reported as fresh
  // when it is shown next frame.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cap[k] <= '0;
      end
      fresh <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (i_probe_stb[k]) begin
          cap[k]   <= i_probe[64*k +: 64];
          fresh[k] <= 1'b1;
        end else if (do_xfer && (sel == 3'(k))) begin
          fresh[k] <= 1'b0;
        end
      end
    end
  end

  // Selection and display registers. The mode is the i_auto level itself:
  // in manual mode fcnt is held at zero, which also clears it on the clock
  // after auto is dropped. The transfer samples the pre-advance sel.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      sel         <= 3'd0;
      fcnt        <= 12'd0;
      // Start the edge detectors "high" so an origin or button already
      // asserted at reset release is not taken as an event.
      org_d       <= 1'b1;
      next_d      <= 1'b1;
      o_debug     <= 64'd0;
      o_chan      <= 3'd0;
      o_stale     <= 1'b1;
      o_frame_stb <= 1'b0;
    end else begin
      org_d       <= at_org;
      next_d      <= i_next;
      o_frame_stb <= xfer;

      if (advance) begin
        sel <= sel_next;
      end

      if (!i_auto || advance) begin
        fcnt <= 12'd0;
      end else if (xfer) begin
        fcnt <= fcnt + 12'd1;
      end

      if (do_xfer) begin
        o_debug <= cap_sel;
        o_chan  <= sel;
        o_stale <= !fresh_sel;
      end
    end
  end

endmodule

// File: tb/tb_debug_probe_sched.sv
// tb/tb_debug_probe_sched.sv - scoreboard bench for debug_probe_sched
module tb_debug_probe_sched;

  localparam int NCH = 4;
  localparam int FPC = 3;

  logic              clk = 1'b0;
  logic              i_reset;
  logic [11:0]       i_h;
  logic [11:0]       i_v;
  logic [64*NCH-1:0] i_probe;
  logic [NCH-1:0]    i_probe_stb;
  logic              i_next;
  logic              i_auto;
  logic              i_freeze;
  logic [63:0]       o_debug;
  logic [2:0]        o_chan;
  logic              o_stale;
  logic              o_frame_stb;

  debug_probe_sched #(.NUM_CH(NCH), .FRAMES_PER_CH(FPC)) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_h         (i_h),
    .i_v         (i_v),
    .i_probe     (i_probe),
    .i_probe_stb (i_probe_stb),
    .i_next      (i_next),
    .i_auto      (i_auto),
    .i_freeze    (i_freeze),
    .o_debug     (o_debug),
    .o_chan      (o_chan),
    .o_stale     (o_stale),
    .o_frame_stb (o_frame_stb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] dbg;
    logic [2:0]  chan;
    logic        stale;
  } disp_t;

  disp_t exp_q[$];
  int    checks        = 0;
  int    failures      = 0;
  int    frames_pushed = 0;
  int    stb_seen      = 0;

  // Frame-level reference model: snapshots, freshness, selected channel and
  // how many frames the current channel has been shown in auto mode.
  logic [63:0] m_cap [NCH];
  bit          m_fresh [NCH];
  int          m_sel;
  int          m_dwell;
  bit          m_auto;
  bit          m_freeze;
  disp_t       m_disp;

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_cap[k]   = 64'd0;
      m_fresh[k] = 1'b0;
    end
    m_sel        = 0;
    m_dwell      = 0;
    m_disp.dbg   = 64'd0;
    m_disp.chan  = 3'd0;
    m_disp.stale = 1'b1;
  endfunction

  function automatic void model_advance();
    m_sel   = (m_sel + 1) % NCH;
    m_dwell = 0;
  endfunction

  // One displayed frame: show the current channel (unless frozen), then apply
  // any strobe/press that coincided with the origin, then the dwell rule.
  function automatic void model_frame(bit stb_same, logic [63:0] v, bit next_same);
    int s;
    bit adv;
    s = m_sel;
    if (!m_freeze) begin
      m_disp.dbg   = m_cap[s];
      m_disp.chan  = 3'(s);
      m_disp.stale = !m_fresh[s];
      m_fresh[s]   = 1'b0;
    end
    exp_q.push_back(m_disp);
    frames_pushed++;
    if (stb_same) begin
      m_cap[s]   = v;
      m_fresh[s] = 1'b1;
    end
    adv = next_same;
    if (m_auto) begin
      m_dwell++;
      if (m_dwell == FPC) adv = 1'b1;
    end
    if (adv) model_advance();
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_debug"}, o_debug, 64'd0);
    chk({tag, "_chan"}, 64'(o_chan), 64'd0);
    chk({tag, "_stale"}, 64'(o_stale), 64'd1);
    chk({tag, "_frame_stb"}, 64'(o_frame_stb), 64'd0);
  endtask

  // Monitor: every frame strobe must match the next expected display.
  always @(negedge clk) begin : monitor
    disp_t e;
    if (o_frame_stb === 1'b1) begin
      stb_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_frame_stb at %0t debug=%h chan=%0d", $time, o_debug, o_chan);
      end else begin
        e = exp_q.pop_front();
        if ({o_debug, o_chan, o_stale} !== e) begin
          failures++;
          $display("FAIL frame_out at %0t actual debug=%h chan=%0d stale=%0d required debug=%h chan=%0d stale=%0d",
                   $time, o_debug, o_chan, o_stale, e.dbg, e.chan, e.stale);
        end
      end
    end
  end

  // Drivers: each tick lands on a falling edge and sets a non-origin beam position.
  task automatic tick();
    @(negedge clk);
    i_probe_stb = '0;
    i_h = 12'($urandom_range(1, 4095));
    i_v = 12'($urandom_range(0, 4095));
  endtask

  task automatic strobe(int k, logic [63:0] v);
    tick();
    i_probe[64*k +: 64] = v;
    i_probe_stb[k] = 1'b1;
    m_cap[k]   = v;
    m_fresh[k] = 1'b1;
  endtask

  task automatic strobe_multi(logic [NCH-1:0] mask);
    logic [63:0] v;
    tick();
    for (int k = 0; k < NCH; k++) begin
      if (mask[k]) begin
        v = {$urandom, $urandom};
        i_probe[64*k +: 64] = v;
        i_probe_stb[k] = 1'b1;
        m_cap[k]   = v;
        m_fresh[k] = 1'b1;
      end
    end
  endtask

  task automatic press();
    tick();
    i_next = 1'b1;
    model_advance();
    tick();
    i_next = 1'b0;
  endtask

  task automatic frame(int len, bit stb_same, logic [63:0] v, bit next_same);
    tick();
    i_h = 12'd0;
    i_v = 12'd0;
    if (stb_same) begin
      i_probe[64*m_sel +: 64] = v;
      i_probe_stb[m_sel] = 1'b1;
    end
    if (next_same) i_next = 1'b1;
    model_frame(stb_same, v, next_same);
    for (int j = 1; j < len; j++) begin
      tick();
      i_h = 12'd0;
      i_v = 12'd0;
      if (next_same) i_next = 1'b0;
    end
    tick();
    if (next_same) i_next = 1'b0;
    repeat ($urandom_range(0, 3)) tick();
  endtask

  task automatic set_auto(bit b);
    tick();
    i_auto = b;
    m_auto = b;
    if (!b) m_dwell = 0;
  endtask

  task automatic set_freeze(bit b);
    tick();
    i_freeze = b;
    m_freeze = b;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin : stim
    i_reset     = 1'b1;
    i_h         = 12'd0;
    i_v         = 12'd0;
    i_probe     = '0;
    i_probe_stb = '0;
    i_next      = 1'b0;
    i_auto      = 1'b0;
    i_freeze    = 1'b0;
    m_auto      = 1'b0;
    m_freeze    = 1'b0;
    model_reset();

    // Reset released while the origin is held: no transfer may fire.
    repeat (3) @(negedge clk);
    check_reset("reset");
    i_reset = 1'b0;
    repeat (3) @(negedge clk);

    // Reset and first frame, then a stale repeat.
    strobe(0, 64'h0123456789ABCDEF);
    frame(1, 1'b0, 64'd0, 1'b0);
    frame(1, 1'b0, 64'd0, 1'b0);

    // Manual wrap over five presses, then a held button over three frames.
    repeat (5) begin
      press();
      frame(1, 1'b0, 64'd0, 1'b0);
    end
    tick();
    i_next = 1'b1;
    model_advance();
    repeat (3) frame(1, 1'b0, 64'd0, 1'b0);
    tick();
    i_next = 1'b0;

    // Back to channel 0, then auto dwell and a press coinciding with the wrap.
    press();
    press();
    set_auto(1'b1);
    repeat (12) frame(1, 1'b0, 64'd0, 1'b0);
    frame(1, 1'b0, 64'd0, 1'b0);
    frame(1, 1'b0, 64'd0, 1'b0);
    frame(1, 1'b0, 64'd0, 1'b1);
    frame(1, 1'b0, 64'd0, 1'b0);
    set_auto(1'b0);

    // Freeze on channel 2.
    press();
    strobe(2, 64'hAA);
    frame(1, 1'b0, 64'd0, 1'b0);
    set_freeze(1'b1);
    strobe(2, 64'hBB);
    repeat (5) frame(1, 1'b0, 64'd0, 1'b0);
    set_freeze(1'b0);
    frame(1, 1'b0, 64'd0, 1'b0);

    // Strobe in the exact transfer cycle.
    strobe(2, 64'h44);
    frame(1, 1'b1, 64'h55, 1'b0);
    frame(1, 1'b0, 64'd0, 1'b0);

    // Multi-clock origin, then reset while the origin is held.
    frame(4, 1'b0, 64'd0, 1'b0);
    tick();
    i_h = 12'd0;
    i_v = 12'd0;
    i_reset = 1'b1;
    tick();
    i_h = 12'd0;
    i_v = 12'd0;
    check_reset("midreset");
    model_reset();
    i_reset = 1'b0;
    repeat (3) begin
      tick();
      i_h = 12'd0;
      i_v = 12'd0;
    end
    tick();
    frame(1, 1'b0, 64'd0, 1'b0);

    // Randomized mix of captures, presses, mode and freeze changes and frames.
    repeat (250) begin
      case ($urandom_range(0, 9))
        0, 1: strobe_multi(NCH'($urandom_range(1, (1 << NCH) - 1)));
        2:    press();
        3:    set_auto(!m_auto);
        4:    set_freeze(!m_freeze);
        default: frame($urandom_range(1, 3), ($urandom_range(0, 7) == 0),
                       {$urandom, $urandom}, ($urandom_range(0, 7) == 0));
      endcase
    end

    repeat (4) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("frame_count", 64'(stb_seen), 64'(frames_pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_probe_sched.md
# debug_probe_sched

Frame-synchronous scheduler that shares the single 64-bit hex debug overlay between up to `NUM_CH` probe sources. It captures each probe on its strobe and selects one channel per display period, either manually or by auto-cycling. At frame origin it transfers the selected snapshot to the overlay, so digits never tear mid-frame. It sits between the core's debug taps and the overlay's `i_debug`, `i_h` and `i_v` inputs, in the same pixel clock domain.

## Interface
- `NUM_CH`, default 4: number of probe channels; legal range 2..8.
- `FRAMES_PER_CH`, default 60: frames each channel is shown in auto mode; legal range 1..4095.

- `clk`  in  1: pixel clock; all logic on its rising edge.
- `i_reset`  in  1: synchronous reset, active-high.
- `i_h`  in  12: horizontal beam counter; same signal that feeds the overlay.
- `i_v`  in  12: vertical beam counter.
- `i_probe`  in  64*NUM_CH: probe values; channel k is bits [64k+63:64k].
- `i_probe_stb`  in  NUM_CH: per-channel capture strobe, one clock per value.
- `i_next`  in  1: debounced manual-advance level, for example an OSD button; acts on its rising edge.
- `i_auto`  in  1: level; 1 enables auto-cycling.
- `i_freeze`  in  1: level; 1 holds all display outputs.
- `o_debug`  out  64: value shown by the overlay.
- `o_chan`  out  3: channel index currently displayed.
- `o_stale`  out  1: 1 when the displayed snapshot had no new strobe since that channel was last displayed.
- `o_frame_stb`  out  1: one-clock pulse on each frame-origin transfer.

## Operation
- **Capture bank.** Per channel there is a 64-bit `cap[k]` register and a `fresh[k]` bit.
  - When `i_probe_stb[k]` is 1: `cap[k]` <= channel k of `i_probe`, and `fresh[k]` <= 1.
  - Strobes on several channels in the same cycle are all captured independently.
- **Frame origin.**
  - `at_org` = (`i_h`==0 && `i_v`==0).
  - `org_d` is `at_org` registered.
  - The transfer event is `xfer` = `at_org` && !`org_d`. It fires exactly once per frame, even if the origin lasts several clocks.
- **Transfer.** When `xfer` is 1 and `i_freeze` is 0:
  - `o_debug` <= `cap[sel]`.
  - `o_chan` <= `sel`.
  - `o_stale` <= !`fresh[sel]`.
  - `fresh[sel]` <= 0, unless `i_probe_stb[sel]` is also 1 in that cycle.
  - Same-cycle strobe on `sel`: the display takes the old `cap[sel]` and `fresh[sel]` stays 1, because the strobe wins.
- **`o_frame_stb`** is 1 for the cycle after every `xfer`, whether or not `i_freeze` is set.
- **Freeze.** While `i_freeze` is 1, `o_debug`, `o_chan` and `o_stale` hold. Captures, `sel` changes and the frame counter continue to run. Releasing freeze takes effect at the next `xfer`.
- **Selection FSM.** `sel` is 3 bits and `fcnt` is 12 bits.
  - MANUAL state (`i_auto`=0):
    - A rising edge of `i_next` advances `sel`.
    - `fcnt` stays 0.
  - AUTO state (`i_auto`=1):
    - `fcnt` increments on each `xfer`.
    - When `xfer` occurs with `fcnt`==`FRAMES_PER_CH`-1, `sel` advances and `fcnt` <= 0.
    - A rising edge of `i_next` also advances `sel` and sets `fcnt` <= 0.
  - Advance rule: `sel` goes to 0 if `sel`==`NUM_CH`-1, otherwise `sel`+1.
  - A manual edge and an auto advance in the same cycle produce one advance only.
  - Switching AUTO to MANUAL clears `fcnt` on the next clock.
- **Edge detect.** `next_d` is `i_next` registered. A rising edge is `i_next` && !`next_d`.
- **Selection vs. transfer in one cycle.** A `sel` change and an `xfer` in the same cycle: the transfer uses the old `sel`. The new `sel` is first displayed at the next frame.

## Timing
- **Reset values.**
  - `o_debug` = 0, `o_chan` = 0, `o_stale` = 1, `o_frame_stb` = 0.
  - `sel` = 0, `fcnt` = 0.
  - All `cap` = 0 and all `fresh` = 0.
  - `org_d` = 1 and `next_d` = 1. This means no spurious `xfer` or advance if the origin or button is already asserted when reset releases.
- **Reset mid-frame:** the first transfer occurs at the next true origin.
- **Capture latency:** a strobe at edge N makes the value available to a transfer at edge N+1 or later.
- **Display latency:** outputs change on the same edge that samples `xfer`, i.e. 1 clock after the origin appears on `i_h`/`i_v`. `o_frame_stb` is high for that following cycle. The overlay's own pipeline delay is downstream and not compensated here.
- **Advance latency:** a `sel` change on an `i_next` edge completes 1 clock after the edge. `o_chan` reflects it at the next unfrozen `xfer`.
- **Auto dwell:** each channel is shown for exactly `FRAMES_PER_CH` transfers. With `FRAMES_PER_CH`=1, the channel changes every frame.
- **Throughput:** no stall or handshake. Strobes are accepted every clock.

## Test plan
- **Reset and first frame.** Reset, then strobe ch0 with 0x0123456789ABCDEF, then drive the origin. Required: on the next clock `o_debug`=0x0123456789ABCDEF, `o_chan`=0, `o_stale`=0 and `o_frame_stb`=1 for one clock. A second frame with no strobe gives `o_stale`=1.
- **Manual wrap.** `NUM_CH`=4. Pulse `i_next` 5 times, with one frame after each pulse. Required: `o_chan` goes 1, 2, 3, 0, 1. Holding `i_next` high over 3 frames produces only one advance.
- **Auto dwell.** `FRAMES_PER_CH`=3 and `i_auto`=1. Required: over 12 frames `o_chan` reads 0,0,0,1,1,1,2,2,2,3,3,3. An `i_next` edge in the same cycle as the third `xfer` advances `sel` by one, not two.
- **Freeze.** Freeze while ch2 shows 0xAA, then strobe ch2 with 0xBB and run 5 frames. Required: `o_debug` stays 0xAA and `o_frame_stb` still pulses every frame. Release freeze: the next frame shows 0xBB with `o_stale`=0.
- **Strobe at origin.** Strobe `sel` with 0x55 in the exact cycle of `xfer`, with `cap`=0x44. Required: `o_debug`=0x44. The next frame shows 0x55 with `o_stale`=0.
- **Multi-cycle origin and mid-operation reset.** Hold `i_h`=`i_v`=0 for 4 clocks. Required: exactly one `o_frame_stb`. Assert `i_reset` mid-frame while the origin is high. Required: all outputs return to their reset values and no `xfer` fires until the origin is deasserted and then reasserted.
